// File: rtl/door_controller.sv
// Elevator door sequencing FSM: opens on arrival/request, closes on dwell expiry or button,
// reopens on obstruction, drives the dwell timer and supervises travel with a limit-switch timeout.
module door_controller #(
  parameter int unsigned TRAVEL_MAX = 200_000_000
) (
  input  logic C_100Mhz,
  input  logic reset_n,
  input  logic arrive,
  input  logic btn_open,
  input  logic btn_close,
  input  logic obstruction,
  input  logic lim_open,
  input  logic lim_closed,
  input  logic timeExpired,
  output logic startTimer,
  output logic restart,
  output logic motor_open,
  output logic motor_close,
  output logic door_closed,
  output logic fault
);

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam logic [27:0] TRAVEL_LAST = 28'(TRAVEL_MAX - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [27:0] travel_cnt_r;
  logic        travel_done_s;
  logic        hold_s;
  logic        sensor_bad_s;

  assign travel_done_s = (travel_cnt_r == TRAVEL_LAST);
  assign hold_s        = btn_open | obstruction;
  assign sensor_bad_s  = lim_open & lim_closed;

  // Next-state decode; a contradictory limit-switch pair beats every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if ((state_r != ST_FAULT) && sensor_bad_s) begin
      state_nxt_s = ST_FAULT;
    end else begin
      case (state_r)
        ST_CLOSED: begin
          if (arrive || btn_open) state_nxt_s = ST_OPENING;
          else                    state_nxt_s = ST_CLOSED;
        end
        ST_OPENING: begin
          if (lim_open)           state_nxt_s = ST_OPEN;
          else if (travel_done_s) state_nxt_s = ST_FAULT;
          else                    state_nxt_s = ST_OPENING;
        end
        ST_OPEN: begin
          // While restart is on the wire the timer is being cleared, so no close is taken.
          if (hold_s || restart)              state_nxt_s = ST_OPEN;
          else if (btn_close || timeExpired)  state_nxt_s = ST_CLOSING;
          else                                state_nxt_s = ST_OPEN;
        end
        ST_CLOSING: begin
          if (hold_s)             state_nxt_s = ST_OPENING;
          else if (lim_closed)    state_nxt_s = ST_CLOSED;
          else if (travel_done_s) state_nxt_s = ST_FAULT;
          else                    state_nxt_s = ST_CLOSING;
        end
        ST_FAULT: state_nxt_s = ST_FAULT;
        default:  state_nxt_s = ST_FAULT;
      endcase
    end
  end

  // State, travel counter and outputs, all decoded from the next state on the same edge.
  always_ff @(posedge C_100Mhz) begin
    if (!reset_n) begin
      state_r      <= ST_CLOSED;
      travel_cnt_r <= 28'd0;
      startTimer   <= 1'b0;
      restart      <= 1'b0;
      motor_open   <= 1'b0;
      motor_close  <= 1'b0;
      door_closed  <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) begin
        travel_cnt_r <= 28'd0;
      end else if ((state_r == ST_OPENING) || (state_r == ST_CLOSING)) begin
        travel_cnt_r <= travel_cnt_r + 28'd1;
      end else begin
        travel_cnt_r <= 28'd0;
      end
      startTimer  <= (state_nxt_s == ST_OPEN);
      restart     <= (state_nxt_s == ST_OPEN) && ((state_r != ST_OPEN) || hold_s);
      motor_open  <= (state_nxt_s == ST_OPENING);
      motor_close <= (state_nxt_s == ST_CLOSING);
      door_closed <= (state_nxt_s == ST_CLOSED) && lim_closed;
      fault       <= (state_nxt_s == ST_FAULT);
    end
  end

endmodule

// File: doc/door_controller.md
# door_controller

Elevator door sequencing FSM sitting directly upstream of the door timer/divider. It opens the door on arrival or request and drives the timer's `startTimer`/`restart` inputs. It closes on timer expiry or the close button and reopens on obstruction. It reports a safe-to-move `door_closed` flag to the motion controller. Travel is supervised by a limit-switch timeout that latches a fault.

## Interface
- `TRAVEL_MAX`, default 200_000_000: cycles allowed for open/close travel, 2 s at 100 MHz. Legal range 2 to 2^28−1.
- `C_100Mhz`  in  1  system clock, 100 MHz.
- `reset_n`  in  1  synchronous, active-low reset, sampled on rising edge of `C_100Mhz`.
- `arrive`  in  1  one-cycle pulse: car stopped at a floor, request door cycle.
- `btn_open`  in  1  door-open button, level, already synchronized.
- `btn_close`  in  1  door-close button, level, already synchronized.
- `obstruction`  in  1  light-curtain blocked, level.
- `lim_open`  in  1  door fully-open limit switch.
- `lim_closed`  in  1  door fully-closed limit switch.
- `timeExpired`  in  1  dwell-timer expiry from the timer. Cleared by the timer on `restart`.
- `startTimer`  out  1  enables timer counting.
- `restart`  out  1  one-cycle timer clear.
- `motor_open`  out  1  drive door toward open.
- `motor_close`  out  1  drive door toward closed.
- `door_closed`  out  1  car may move.
- `fault`  out  1  sticky fault indication.

## Operation
- States: CLOSED, OPENING, OPEN, CLOSING, FAULT. Reset state is CLOSED.
- CLOSED:
  - `arrive` or `btn_open` → OPENING.
  - `door_closed` = `lim_closed`.
- OPENING:
  - `motor_open`=1.
  - `lim_open` → OPEN.
  - Travel counter reaching `TRAVEL_MAX`−1 without `lim_open` → FAULT.
- OPEN:
  - `startTimer`=1 throughout.
  - `restart`=1 on the entry cycle.
  - `restart`=1 on every cycle with `btn_open` or `obstruction` high; dwell is held.
  - `timeExpired` is ignored on the entry cycle and on any cycle where `restart` is being driven.
  - Otherwise, `btn_close` or `timeExpired` → CLOSING.
- CLOSING:
  - `motor_close`=1 and `startTimer`=0.
  - `obstruction` or `btn_open` → OPENING. This has priority over `lim_closed` in the same cycle.
  - Otherwise, `lim_closed` → CLOSED.
  - Travel timeout → FAULT.
- FAULT:
  - `fault`=1; `motor_open`, `motor_close`, `startTimer`, `restart`, and `door_closed` are all 0.
  - Exit only by reset.
- Travel counter:
  - 28-bit, cleared on entry to OPENING or CLOSING, increments each cycle in those states.
  - Compare is `==TRAVEL_MAX−1`; the counter never wraps.
- Sensor inconsistency: `lim_open` and `lim_closed` both high in any non-FAULT state → FAULT. This has priority over all other transitions.
- `arrive` in any state other than CLOSED is ignored; the door is already cycling.
- `motor_open` and `motor_close` are never both 1.

## Timing
- All outputs are registered and decoded from the next state. An output changes on the same clock edge as the state it belongs to.
- Latency: input sampled at edge N → state and outputs updated at edge N.
- Reset (`reset_n`=0 at an edge):
  - State CLOSED, travel counter 0.
  - All outputs 0, including `door_closed`. `door_closed` rises one cycle later if `lim_closed`=1.
  - Reset mid-OPENING or mid-CLOSING stops the motor on that edge.
- The `restart` entry pulse is exactly one cycle wide unless extended by `btn_open` or `obstruction`.
- Earliest close after entering OPEN is 2 cycles later, via `btn_close`.
- Travel timeout: FAULT is entered exactly `TRAVEL_MAX` cycles after the edge that entered OPENING or CLOSING.

## Test plan
- Normal cycle:
  - Reset, `lim_closed`=1 → `door_closed`=1.
  - Pulse `arrive` → `motor_open`=1 next edge.
  - Raise `lim_open` → OPEN, `restart`=1 for one cycle, `startTimer`=1.
  - `timeExpired`=1 → CLOSING, `motor_close`=1.
  - `lim_closed` → CLOSED, `door_closed`=1.
- Dwell hold: in OPEN, hold `obstruction` 5 cycles → `restart`=1 for 5 cycles and no transition even with `timeExpired`=1. Then release → CLOSING.
- Reopen: in CLOSING, `obstruction`=1 and `lim_closed`=1 on the same cycle → OPENING, `motor_open`=1, `motor_close`=0.
- Timeout: `TRAVEL_MAX`=16, enter OPENING with `lim_open` held 0 → `fault`=1 at cycle 16. Further `arrive` or `btn_open` are ignored, and only `reset_n`=0 clears the fault.
- Sensor fault: in OPEN, drive `lim_open`=`lim_closed`=1 → FAULT next edge, all drive outputs 0.
- Reset mid-CLOSING: `reset_n`=0 → next edge `motor_close`=0, state CLOSED, `fault`=0.
